i2c_slave_rx: RTL and testbench
===============================

// Module: i2c_slave_rx
// PURPOSE
//  Write-receive I2C target that sits on the bus driven by i2c_master and consumes its frames.
//  Oversamples SCL/SDA on the system clock, detects START/STOP and matches its 7-bit address.
//  Open-drain ACKs the address and each data byte, then presents every received byte on a
//  parallel output with a one-cycle strobe.
//  Direction is fixed: receive only. The R/W bit is captured and reported but does not turn
//  the bus around.
// PARAMETERS
//  SLAVE_ADDR   7'h5A  7-bit target address, compared against address byte bits [7:1]
//  SYNC_STAGES  2      flip-flop synchronizer depth on SCL and SDA inputs (>=2)
// PORTS
//  clk         in     1  system clock
//  reset       in     1  asynchronous, active-high reset
//  scl         in     1  I2C clock (external pull-up)
//  sda         inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only
//  data_out    out    8  last received data byte, MSB first on bus
//  data_valid  out    1  one-clk pulse, data_out updated this cycle
//  rw_bit      out    1  R/W bit (address byte bit0) of current/last matched transaction
//  addr_match  out    1  high from matched-address ACK until STOP/START
//  busy        out    1  high between START and STOP (any address)
// BEHAVIOUR
//  Reset: sda=z, data_out=0, data_valid=0, rw_bit=0, addr_match=0, busy=0, state=IDLE,
//    synchronizers loaded with 1.
//  Sampling
//    - scl/sda pass SYNC_STAGES FFs plus one history FF.
//    - All edges are evaluated on the synced values.
//    - Requirement on the bus: SCL high and low phases each >= SYNC_STAGES+3 clk.
//  START = sda_s falls while scl_s high.   STOP = sda_s rises while scl_s high.
//    - Both override every state.
//    - START: bit_cnt=0, busy=1, addr_match=0, goto ADDR.
//    - STOP: goto IDLE, busy=0, addr_match=0, sda released.
//  Bit sampling
//    - Shift sda_s into shift reg on each scl_s rising edge, MSB first.
//    - bit_cnt 0..7; the 8th rise completes the byte.
//  States
//    IDLE      wait for START; sda=z.
//    ADDR      8 bits shifted in.
//              - If shift[7:1]==SLAVE_ADDR: latch rw_bit=shift[0]; on next scl_s fall drive
//                sda=0; addr_match=1; goto ADDR_ACK.
//              - Else: goto IGNORE.
//    ADDR_ACK  hold sda=0 through 9th SCL high; on following scl_s fall release sda;
//              bit_cnt=0; goto DATA.
//    DATA      8 bits shifted in. On the 8th scl_s rise: data_out<=shift and data_valid=1
//              for exactly 1 clk (latency 1 clk after the sampled edge). Then on scl_s fall
//              drive sda=0; goto DATA_ACK.
//    DATA_ACK  as ADDR_ACK, then back to DATA (unbounded bytes per transaction).
//    IGNORE    sda=z; wait for START or STOP only.
//  Boundaries
//    - Repeated START mid-byte: partial byte discarded, no data_valid, re-address.
//    - STOP mid-byte: partial byte discarded, no data_valid.
//    - START/STOP cannot be seen while this block holds sda low (ACK phase); edges caused
//      by its own release are not START/STOP because release occurs with scl low.
//    - Reset mid-ACK: sda goes z asynchronously; all outputs to reset values.
//    - data_out holds its value until the next completed data byte.
// TESTING  (bench: i2c_master CLKS_PER_BIT=12, CLKS_PER_BIT_HALF=6, pullups on sda/scl)
//  1. Reset, master addr 8'hB4, data 8'hA2 -> sda=0 on both 9th SCL highs; one data_valid
//     pulse; data_out=8'hA2; rw_bit=0; busy=0 after STOP.
//  2. addr 8'hB5, data 8'h3C -> ACKs, rw_bit=1, data_out=8'h3C, one pulse.
//  3. addr 8'h40, data 8'hFF -> sda never driven 0 by slave; no data_valid; addr_match
//     stays 0; data_out keeps 8'h3C.
//  4. addr 8'hB4, data 8'h11 then 8'h22, one STOP -> two pulses, values 8'h11 then 8'h22,
//     three ACKs.
//  5. addr 8'hB4, repeated START after 4 data bits, addr 8'hB4, data 8'h5A -> single
//     pulse, data_out=8'h5A.
//  6. reset asserted during data ACK low phase -> sda=z within the reset cycle; all
//     outputs at reset values.

Source files
------------

// File: rtl/i2c_slave_rx_if.sv
// Parallel receive-side outputs of the I2C write target, grouped so the
// consumer of received bytes connects through a single port.
interface i2c_slave_rx_if;
    logic [7:0] data_out;
    logic       data_valid;
    logic       rw_bit;
    logic       addr_match;
    logic       busy;

    modport slave (
        output data_out,
        output data_valid,
        output rw_bit,
        output addr_match,
        output busy
    );

    modport master (
        input data_out,
        input data_valid,
        input rw_bit,
        input addr_match,
        input busy
    );
endinterface

// File: rtl/i2c_slave_rx.sv
// Receive-only I2C target: oversamples SCL/SDA, detects START/STOP, matches a
// 7-bit address, ACKs address and data bytes and strobes out each data byte.
module i2c_slave_rx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    i2c_slave_rx_if.slave rx
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_h, sda_h;
    logic                   scl_s, sda_s;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_valid_q, data_valid_d;
    logic       rw_q, rw_d;
    logic       match_q, match_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] next_byte;

    // Synchronizers idle high so a released bus produces no edges after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value, making the chain a true shift.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_h    <= scl_sync[SYNC_STAGES-1];
            sda_h    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
    assign next_byte = {shift_q[6:0], sda_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_done_q  <= 1'b0;
            sda_low_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            rw_q         <= 1'b0;
            match_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            sda_low_q    <= sda_low_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            rw_q         <= rw_d;
            match_q      <= match_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        sda_low_d    = sda_low_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        rw_d         = rw_q;
        match_d      = match_q;
        busy_d       = busy_q;

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            sda_low_d   = 1'b0;
            match_d     = 1'b0;
            busy_d      = 1'b1;
        end else if (stop_det) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            sda_low_d   = 1'b0;
            match_d     = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE, IGNORE: ;
                ADDR: begin
                    // After the 8th bit of a matching address, ACK starts on the next SCL fall.
                    if (byte_done_q) begin
                        if (scl_fall) begin
                            sda_low_d   = 1'b1;
                            match_d     = 1'b1;
                            byte_done_d = 1'b0;
                            state_d     = ADDR_ACK;
                        end
                    end else if (scl_rise) begin
                        shift_d = next_byte;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            if (next_byte[7:1] == SLAVE_ADDR) begin
                                rw_d        = next_byte[0];
                                byte_done_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    // Entered on a fall, so the next fall follows the 9th SCL high.
                    if (scl_fall) begin
                        sda_low_d = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end
                end
                DATA: begin
                    if (byte_done_q) begin
                        if (scl_fall) begin
                            sda_low_d   = 1'b1;
                            byte_done_d = 1'b0;
                            state_d     = DATA_ACK;
                        end
                    end else if (scl_rise) begin
                        shift_d = next_byte;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d    = '0;
                            data_out_d   = next_byte;
                            data_valid_d = 1'b1;
                            byte_done_d  = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Open-drain: the flop clears asynchronously, so reset releases SDA at once.
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    assign rx.data_out   = data_out_q;
    assign rx.data_valid = data_valid_q;
    assign rx.rw_bit     = rw_q;
    assign rx.addr_match = match_q;
    assign rx.busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench: behavioural I2C master plus a transaction-level model of
// which bytes the target must ACK and present, directed cases then random ones.
module tb_i2c_slave_rx;

    logic clk;
    logic reset;
    logic scl;
    logic m_sda_low;
    wire  sda;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_all[$];
    int         match_cnt = 0;
    int         drive_cnt = 0;
    logic [7:0] tx_q[$];

    logic [7:0] exp_dout;
    logic       exp_rw;

    i2c_slave_rx_if rx_if ();

    i2c_slave_rx #(
        .SLAVE_ADDR (7'h5A),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .scl  (scl),
        .sda  (sda),
        .rx   (rx_if.slave)
    );

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observer: records strobed bytes and whether the target matched or drove SDA.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.data_valid) got_all.push_back(rx_if.data_out);
            if (rx_if.addr_match) match_cnt++;
            if (sda == 1'b0 && !m_sda_low) drive_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b);
        tick(4);
        m_sda_low = ~b;
        tick(2);
        scl = 1'b1;
        tick(6);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        tick(4);
        m_sda_low = 1'b0;
        tick(2);
        scl = 1'b1;
        tick(3);
        ack = (sda == 1'b0);
        tick(3);
        scl = 1'b0;
    endtask

    task automatic master_start();
        if (scl == 1'b0) begin
            tick(4);
            m_sda_low = 1'b0;
            tick(2);
            scl = 1'b1;
            tick(6);
        end
        m_sda_low = 1'b1;
        tick(6);
        scl = 1'b0;
    endtask

    task automatic master_stop();
        tick(4);
        m_sda_low = 1'b1;
        tick(2);
        scl = 1'b1;
        tick(6);
        m_sda_low = 1'b0;
        tick(6);
    endtask

    // One transaction of tx_q bytes, optionally cut short by a STOP after abort_bits bits.
    task automatic run_txn(input logic [7:0] addr, input int abort_bits);
        logic [7:0] exp_q[$];
        logic       exp_m;
        logic       ack;
        int         base_v, base_m, base_d;
        base_v = got_all.size();
        base_m = match_cnt;
        base_d = drive_cnt;
        exp_m  = (addr[7:1] == 7'h5A);

        master_start();
        check("busy_after_start", rx_if.busy, 1'b1);
        send_byte(addr, ack);
        check("addr_ack", ack, exp_m);
        foreach (tx_q[i]) begin
            send_byte(tx_q[i], ack);
            check("data_ack", ack, exp_m);
            if (exp_m) exp_q.push_back(tx_q[i]);
        end
        for (int i = 0; i < abort_bits; i++) send_bit(1'($urandom_range(0, 1)));
        master_stop();

        if (exp_m) begin
            exp_rw = addr[0];
            if (exp_q.size() > 0) exp_dout = exp_q[exp_q.size()-1];
        end
        check("valid_count", got_all.size() - base_v, exp_q.size());
        foreach (exp_q[i]) begin
            if (base_v + i < got_all.size()) check("data_byte", got_all[base_v+i], exp_q[i]);
        end
        check("addr_match_seen", match_cnt > base_m, exp_m);
        check("slave_drove_sda", drive_cnt > base_d, exp_m);
        check("data_out", rx_if.data_out, exp_dout);
        check("rw_bit", rx_if.rw_bit, exp_rw);
        check("busy_after_stop", rx_if.busy, 1'b0);
        check("match_after_stop", rx_if.addr_match, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda"}, sda, 1'b1);
        check({tag, "_data_out"}, rx_if.data_out, 8'h00);
        check({tag, "_data_valid"}, rx_if.data_valid, 1'b0);
        check({tag, "_rw_bit"}, rx_if.rw_bit, 1'b0);
        check({tag, "_addr_match"}, rx_if.addr_match, 1'b0);
        check({tag, "_busy"}, rx_if.busy, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] addr;
        int         base_v, nb, abort_bits;

        reset     = 1'b1;
        scl       = 1'b1;
        m_sda_low = 1'b0;
        exp_dout  = 8'h00;
        exp_rw    = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(4);
        check_reset_outputs("idle");

        // Write, matched address
        tx_q = '{8'hA2};
        run_txn(8'hB4, 0);

        // R/W bit set, still received
        tx_q = '{8'h3C};
        run_txn(8'hB5, 0);

        // Foreign address ignored
        tx_q = '{8'hFF};
        run_txn(8'h40, 0);

        // Two bytes in one transaction
        tx_q = '{8'h11, 8'h22};
        run_txn(8'hB4, 0);

        // Repeated START after four data bits
        base_v = got_all.size();
        master_start();
        send_byte(8'hB4, ack);
        check("rs_first_addr_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        tx_q = '{8'h5A};
        run_txn(8'hB4, 0);
        check("rs_total_pulses", got_all.size() - base_v, 1);

        // Reset while holding a data ACK
        master_start();
        send_byte(8'hB4, ack);
        check("rst_addr_ack", ack, 1'b1);
        for (int i = 7; i >= 0; i--) send_bit(addr_bit(8'hA5, i));
        m_sda_low = 1'b0;
        tick(4);
        check("rst_ack_driven", sda, 1'b0);
        reset = 1'b1;
        #1;
        check("rst_sda_released", sda, 1'b1);
        tick(1);
        check_reset_outputs("midack");
        scl = 1'b1;
        tick(4);
        reset = 1'b0;
        exp_dout = 8'h00;
        exp_rw   = 1'b0;
        tick(4);
        check_reset_outputs("post_rst");

        // Randomized transactions
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) addr = {7'h5A, 1'($urandom_range(0, 1))};
            else addr = 8'($urandom);
            nb = $urandom_range(1, 3);
            tx_q.delete();
            for (int i = 0; i < nb; i++) tx_q.push_back(8'($urandom));
            abort_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
            run_txn(addr, abort_bits);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic addr_bit(input logic [7:0] b, input int i);
        return b[i];
    endfunction

endmodule
